// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared constants for the tile issue path
package tc_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam int TILES_M = 16 / 4;
  localparam int TILES_N = 16 / 4;

  function automatic int tile_count(input int dim, input int tile);
    return dim / tile;
  endfunction

endpackage

// File: rtl/tc_tile_sel.sv
// rtl/tc_tile_sel.sv - combinational TILE_M x TILE_N window extraction from a flat matrix
module tc_tile_sel #(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int TILE_M  = 4,
  parameter int TILE_N  = 4,
  parameter int DW_DATA = 32,
  parameter int DW_POS  = 4
) (
  input  logic [M*N*DW_DATA-1:0]           mat,
  input  logic [DW_POS-1:0]                row,
  input  logic [DW_POS-1:0]                col,
  output logic [TILE_M*TILE_N*DW_DATA-1:0] tile
);

  localparam int IW = $clog2(M*N*DW_DATA);

  for (genvar ti = 0; ti < TILE_M; ti++) begin : g_row
    for (genvar tj = 0; tj < TILE_N; tj++) begin : g_col
      logic [IW-1:0] base;
      assign base = IW'(((int'(row) + ti) * N + int'(col) + tj) * DW_DATA);
      assign tile[(ti*TILE_N+tj)*DW_DATA +: DW_DATA] = mat[base +: DW_DATA];
    end
  end

endmodule

// File: rtl/tc_tile_issue.sv
// rtl/tc_tile_issue.sv - captures an M x N matrix and replays it as column-block-major tiles
module tc_tile_issue
  import tc_pkg::*;
#(
  parameter int M           = 16,
  parameter int N           = 16,
  parameter int TILE_M      = 4,
  parameter int TILE_N      = 4,
  parameter int DW_DATA     = 32,
  parameter int DW_POS      = 4,
  parameter int NUM_TILE_EL = TILE_M * TILE_N
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [M*N*DW_DATA-1:0]         in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_TILE_EL*DW_DATA-1:0] out,
  output logic [DW_POS-1:0]              row,
  output logic [DW_POS-1:0]              col,
  output logic                           out_last,
  output logic                           busy
);

  // Wrap points are compared directly; row+TILE_M may not fit in DW_POS.
  localparam logic [DW_POS-1:0] ROW_END  = DW_POS'(M - TILE_M);
  localparam logic [DW_POS-1:0] COL_END  = DW_POS'(N - TILE_N);
  localparam logic [DW_POS-1:0] ROW_STEP = DW_POS'(TILE_M);
  localparam logic [DW_POS-1:0] COL_STEP = DW_POS'(TILE_N);

  logic [0:0]               state_q, state_d;
  logic [DW_POS-1:0]        row_q, row_d;
  logic [DW_POS-1:0]        col_q, col_d;
  logic [M*N*DW_DATA-1:0]   buf_q, buf_d;
  logic [NUM_TILE_EL*DW_DATA-1:0] tile;
  logic                     issuing;
  logic                     row_at_end;
  logic                     at_last;

  assign issuing    = (state_q == ST_ISSUE);
  assign row_at_end = (row_q == ROW_END);
  assign at_last    = row_at_end && (col_q == COL_END);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          buf_d   = in;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = ST_IDLE;
          end else if (row_at_end) begin
            row_d = '0;
            col_d = col_q + COL_STEP;
          end else begin
            row_d = row_q + ROW_STEP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
    end
  end

  tc_tile_sel #(
    .M       (M),
    .N       (N),
    .TILE_M  (TILE_M),
    .TILE_N  (TILE_N),
    .DW_DATA (DW_DATA),
    .DW_POS  (DW_POS)
  ) u_sel (
    .mat  (buf_q),
    .row  (row_q),
    .col  (col_q),
    .tile (tile)
  );

  assign in_ready  = !issuing;
  assign out_valid = issuing;
  assign busy      = issuing;
  assign out       = issuing ? tile : '0;
  assign row       = issuing ? row_q : '0;
  assign col       = issuing ? col_q : '0;
  assign out_last  = issuing && at_last;

endmodule

// File: tb/tb_tc_tile_issue.sv
// tb/tb_tc_tile_issue.sv - self-checking bench for tc_tile_issue
module tb_tc_tile_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, out_ready, in_ready, out_valid, out_last, busy;
  logic [8191:0]  in_bus;
  logic [511:0]   out_bus;
  logic [3:0]     row, col;

  logic           in_valid2, out_ready2, in_ready2, out_valid2, out_last2, busy2;
  logic [3071:0]  in_bus2;
  logic [511:0]   out_bus2;
  logic [3:0]     row2, col2;

  tc_tile_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_bus), .row(row), .col(col),
    .out_last(out_last), .busy(busy)
  );

  tc_tile_issue #(.M(8), .N(12), .TILE_M(4), .TILE_N(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in(in_bus2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out(out_bus2), .row(row2), .col(col2),
    .out_last(out_last2), .busy(busy2)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] cur [256];

  typedef struct {
    logic rdy;
    int   r;
    int   c;
    logic last;
  } vec_t;
  vec_t tbl [16];
  vec_t tbl2 [6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_tile(input int r, input int c, input int n);
    logic [511:0] t;
    for (int ti = 0; ti < 4; ti++)
      for (int tj = 0; tj < 4; tj++)
        t[(ti*4+tj)*32 +: 32] = cur[(r+ti)*n + c + tj];
    return t;
  endfunction

  function automatic logic [8191:0] pack(input int m, input int n);
    logic [8191:0] p = '0;
    for (int e = 0; e < m*n; e++) p[e*32 +: 32] = cur[e];
    return p;
  endfunction

  task automatic fill_a(input int n);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (j < n) cur[i*n + j] = 32'(i*16 + j);
  endtask

  task automatic load();
    in_valid = 1'b1;
    @(negedge clk);
    chk("load_in_ready", 512'(in_ready), 512'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Walks the straight-through table; ends one edge after the idle-check cycle.
  task automatic play_table(input string tag);
    for (int k = 0; k < 16; k++) begin
      out_ready = tbl[k].rdy;
      @(negedge clk);
      chk({tag, "_valid"}, 512'(out_valid), 512'(1));
      chk({tag, "_in_ready"}, 512'(in_ready), 512'(0));
      chk({tag, "_row"}, 512'(row), 512'(tbl[k].r));
      chk({tag, "_col"}, 512'(col), 512'(tbl[k].c));
      chk({tag, "_last"}, 512'(out_last), 512'(tbl[k].last));
      chk({tag, "_data"}, out_bus, exp_tile(tbl[k].r, tbl[k].c, 16));
      if (tbl[k].r == 4 && tbl[k].c == 0)
        chk({tag, "_el_1_2"}, 512'(out_bus[(1*4+2)*32 +: 32]), 512'(82));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_done_valid"}, 512'(out_valid), 512'(0));
    chk({tag, "_done_in_ready"}, 512'(in_ready), 512'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [511:0] held;
    logic [8191:0] big;
    logic hs;
    int k, stall_cnt, cyc;

    for (int i = 0; i < 16; i++) begin
      tbl[i].rdy  = 1'b1;
      tbl[i].r    = (i % 4) * 4;
      tbl[i].c    = (i / 4) * 4;
      tbl[i].last = (i == 15);
    end
    tbl2[0] = '{1'b1, 0, 0, 1'b0};
    tbl2[1] = '{1'b1, 4, 0, 1'b0};
    tbl2[2] = '{1'b1, 0, 4, 1'b0};
    tbl2[3] = '{1'b1, 4, 4, 1'b0};
    tbl2[4] = '{1'b1, 0, 8, 1'b0};
    tbl2[5] = '{1'b1, 4, 8, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_bus = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_bus2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out", out_bus, 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_rowcol_last", 512'({row, col, out_last}), 512'(0));
    chk("rst2_in_ready", 512'(in_ready2), 512'(1));
    @(posedge clk); #1;

    // Straight run with out_ready held high.
    fill_a(16);
    in_bus = pack(16, 16);
    load();
    play_table("order");

    // Random backpressure with a forced 5-cycle stall on tile (8,4).
    load();
    k = 0; stall_cnt = 0; cyc = 0;
    while (k < 16 && cyc < 300) begin
      if (k == 6 && stall_cnt < 5) out_ready = 1'b0;
      else out_ready = 1'($urandom % 2);
      @(negedge clk);
      chk("bp_valid", 512'(out_valid), 512'(1));
      chk("bp_pos", 512'({row, col}), 512'({4'(tbl[k].r), 4'(tbl[k].c)}));
      chk("bp_last", 512'(out_last), 512'(k == 15));
      chk("bp_data", out_bus, exp_tile(tbl[k].r, tbl[k].c, 16));
      if (k == 6 && stall_cnt < 5) begin
        if (stall_cnt == 0) held = out_bus;
        else chk("bp_stall_hold", out_bus, held);
        stall_cnt++;
      end
      hs = out_ready && out_valid;
      @(posedge clk); #1;
      if (hs) k++;
      cyc++;
    end
    chk("bp_complete", 512'(k), 512'(16));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", 512'(out_valid), 512'(0));
    @(posedge clk); #1;

    // Back-to-back: second matrix offered during the first one's replay.
    load();
    in_valid = 1'b1;
    in_bus = {256{32'hA5A5A5A5}};
    play_table("b2b");
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b2_valid", 512'(out_valid), 512'(1));
    chk("b2b2_pos", 512'({row, col}), 512'(0));
    chk("b2b2_data", out_bus, {16{32'hA5A5A5A5}});
    cyc = 0;
    while (out_valid && cyc < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      cyc++;
    end
    chk("b2b2_drained", 512'(out_valid), 512'(0));
    @(posedge clk); #1;

    // Reset after 6 tiles, with in_valid asserted alongside it.
    in_bus = pack(16, 16);
    load();
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 512'(out_valid), 512'(0));
    chk("mrst_in_ready", 512'(in_ready), 512'(1));
    chk("mrst_busy", 512'(busy), 512'(0));
    chk("mrst_out", out_bus, 512'(0));
    @(posedge clk); #1;
    for (int e = 0; e < 256; e++) cur[e] = $urandom;
    in_bus = pack(16, 16);
    load();
    @(negedge clk);
    chk("mrst_restart_pos", 512'({row, col}), 512'(0));
    chk("mrst_restart_data", out_bus, exp_tile(0, 0, 16));
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Non-square instance: 8 x 12.
    fill_a(12);
    big = pack(8, 12);
    in_bus2 = big[3071:0];
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready2 = tbl2[i].rdy;
      @(negedge clk);
      chk("ns_valid", 512'(out_valid2), 512'(1));
      chk("ns_pos", 512'({row2, col2}), 512'({4'(tbl2[i].r), 4'(tbl2[i].c)}));
      chk("ns_last", 512'(out_last2), 512'(tbl2[i].last));
      chk("ns_data", out_bus2, exp_tile(tbl2[i].r, tbl2[i].c, 12));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ns_done_valid", 512'(out_valid2), 512'(0));
    chk("ns_done_in_ready", 512'(in_ready2), 512'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
